// File: rtl/aes_128_round_sched_if.sv
// Request/result handshake bundle for aes_128_round_sched.
// Defining AES_128_SCHED_ABORT_EN adds the abort line to the bundle.
interface aes_128_round_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher;
`ifdef AES_128_SCHED_ABORT_EN
    logic         abort;
`endif

    modport master (
        output in_valid, in, key, out_ready,
`ifdef AES_128_SCHED_ABORT_EN
        output abort,
`endif
        input  in_ready, out_valid, cipher
    );

    modport slave (
        input  in_valid, in, key, out_ready,
`ifdef AES_128_SCHED_ABORT_EN
        input  abort,
`endif
        output in_ready, out_valid, cipher
    );
endinterface

// File: rtl/aes_128_round_sched.sv
// AES-128 round sequencer: holds state/key registers and steps an external round and key-expansion unit.
// Optional feature: define AES_128_SCHED_ABORT_EN to enable the abort input.
module aes_128_round_sched (
    input  logic                        clk,
    input  logic                        rst,
    aes_128_round_sched_if.slave        bus,
    output logic [127:0]                rnd_state,
    output logic [127:0]                rnd_key,
    output logic [3:0]                  rnd_idx,
    output logic                        rnd_last,
    input  logic [127:0]                rnd_key_in,
    input  logic [127:0]                rnd_state_in
);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] cipher_reg;
    logic [3:0]   idx;

    logic abort_req;
    logic accept;
    logic last;
    logic round_step;

`ifdef AES_128_SCHED_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept     = (fsm_q == IDLE) && bus.in_valid;
    assign last       = (fsm_q == ROUND) && (idx == LAST_ROUND);
    assign round_step = (fsm_q == ROUND) && !abort_req;

    always_comb begin
        // NOTE: default assigned first so no branch leaves fsm_d unassigned and infers a latch.
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (bus.in_valid) fsm_d = ROUND;
            ROUND: begin
                if (abort_req)              fsm_d = IDLE;
                else if (idx == LAST_ROUND) fsm_d = DONE;
            end
            // A same-edge abort during transfer lands in IDLE either way.
            DONE:    if (bus.out_ready || abort_req) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= '0;
            key_reg    <= '0;
            cipher_reg <= '0;
            idx        <= '0;
        end else if (accept) begin
            state_reg <= bus.in ^ bus.key;
            key_reg   <= bus.key;
            idx       <= 4'd1;
        end else if (round_step) begin
            state_reg <= rnd_state_in;
            key_reg   <= rnd_key_in;
            if (last) begin
                cipher_reg <= rnd_state_in;
                idx        <= '0;
            end else begin
                idx <= idx + 4'd1;
            end
        end else if (fsm_q == ROUND) begin
            // Aborted block: the round counter returns to its idle value, cipher keeps the old result.
            idx <= '0;
        end
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.cipher    = cipher_reg;

    assign rnd_state = state_reg;
    assign rnd_key   = key_reg;
    assign rnd_idx   = idx;
    assign rnd_last  = last;
endmodule

// File: tb/tb_aes_128_round_sched.sv
// Self-checking bench for aes_128_round_sched with a behavioural AES round / key-expansion unit on rnd_*.
// Abort tests are built only when AES_128_SCHED_ABORT_EN is defined.
module tb_aes_128_round_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_128_round_sched_if bus_if ();

    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [3:0]   rnd_idx;
    logic         rnd_last;
    logic [127:0] rnd_key_in;
    logic [127:0] rnd_state_in;

    aes_128_round_sched dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .rnd_state    (rnd_state),
        .rnd_key      (rnd_key),
        .rnd_idx      (rnd_idx),
        .rnd_last     (rnd_last),
        .rnd_key_in   (rnd_key_in),
        .rnd_state_in (rnd_state_in)
    );

    // ---------------- AES reference round logic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = b;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        case (i)
            4'd1:  return 8'h01;
            4'd2:  return 8'h02;
            4'd3:  return 8'h04;
            4'd4:  return 8'h08;
            4'd5:  return 8'h10;
            4'd6:  return 8'h20;
            4'd7:  return 8'h40;
            4'd8:  return 8'h80;
            4'd9:  return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int n = 0; n < 16; n++) b[n] = sbox(s[127 - 8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c + r] = b[4*((c + r) % 4) + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = t[n];
        return o ^ k;
    endfunction

    assign rnd_key_in   = key_expand(rnd_key, rcon_of(rnd_idx));
    assign rnd_state_in = aes_round(rnd_state, rnd_key_in, rnd_last);

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input int budget, output int edges);
        edges = 0;
        while (bus_if.out_valid !== 1'b1 && edges < budget) begin
            tick();
            edges++;
        end
    endtask

    // Runs one block from IDLE with out_ready high, checking the round walk and the result.
    task automatic run_vec(input vec_t v);
        logic seq_ok;
        bus_if.in_valid = 1'b1;
        bus_if.in       = v.pt;
        bus_if.key      = v.key;
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.in       = ~v.pt;
        bus_if.key      = ~v.key;
        seq_ok = 1'b1;
        for (int step = 1; step <= 10; step++) begin
            if (rnd_idx !== 4'(step) || rnd_last !== (step == 10) ||
                bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0)
                seq_ok = 1'b0;
            tick();
        end
        check({v.name, " round walk"}, seq_ok, 1);
        check({v.name, " out_valid at 11"}, bus_if.out_valid, 1);
        check({v.name, " cipher"}, bus_if.cipher, v.ct);
        check({v.name, " idx in DONE"}, rnd_idx, 0);
        tick();
        check({v.name, " in_ready after transfer"}, bus_if.in_ready, 1);
        check({v.name, " cipher retained"}, bus_if.cipher, v.ct);
    endtask

    initial begin
        int acc_cyc [2];
        int res_cyc [2];
        int n_acc;
        int n_res;
        int edges;
        logic stall_ok;
        logic acc;

        vecs[0] = '{"fips_b", 128'h3243f6a8885a308d313198a2e0370734,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{"fips_c1", 128'h00112233445566778899aabbccddeeff,
                    128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{"zeros", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in        = '0;
        bus_if.key       = '0;
        bus_if.out_ready = 1'b1;
`ifdef AES_128_SCHED_ABORT_EN
        bus_if.abort     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        check("reset in_ready", bus_if.in_ready, 1);
        check("reset out_valid", bus_if.out_valid, 0);
        check("reset rnd_idx", rnd_idx, 0);
        check("reset rnd_last", rnd_last, 0);
        check("reset cipher", bus_if.cipher, 0);
        check("reset rnd_state", rnd_state, 0);
        check("reset rnd_key", rnd_key, 0);

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Back-to-back requests with in_valid held high.
        n_acc = 0;
        n_res = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in       = vecs[0].pt;
        bus_if.key      = vecs[0].key;
        for (int cyc = 0; cyc < 40 && n_res < 2; cyc++) begin
            acc = bus_if.in_ready;
            if (bus_if.out_valid === 1'b1) begin
                check($sformatf("b2b cipher %0d", n_res), bus_if.cipher, vecs[n_res].ct);
                res_cyc[n_res] = cyc;
                n_res++;
            end
            if (acc === 1'b1 && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
            if (acc === 1'b1) begin
                if (n_acc < 2) begin
                    bus_if.in  = vecs[n_acc].pt;
                    bus_if.key = vecs[n_acc].key;
                end else begin
                    bus_if.in_valid = 1'b0;
                end
            end
        end
        bus_if.in_valid = 1'b0;
        check("b2b result count", n_res, 2);
        if (n_res == 2) begin
            check("b2b accept spacing", acc_cyc[1] - acc_cyc[0], 12);
            check("b2b latency first", res_cyc[0] - acc_cyc[0], 11);
            check("b2b latency second", res_cyc[1] - acc_cyc[1], 11);
        end

        // Consumer stalls for 5 cycles in DONE while new requests are offered.
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in        = vecs[2].pt;
        bus_if.key       = vecs[2].key;
        tick();
        bus_if.in_valid = 1'b0;
        wait_out_valid(20, edges);
        check("stall latency edges", edges, 10);
        stall_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus_if.out_valid !== 1'b1 || bus_if.cipher !== vecs[2].ct || bus_if.in_ready !== 1'b0)
                stall_ok = 1'b0;
            bus_if.in_valid = 1'b1;
            bus_if.in       = {$urandom, $urandom, $urandom, $urandom};
            bus_if.key      = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        check("stall stable", stall_ok, 1);
        check("stall cipher end", bus_if.cipher, vecs[2].ct);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        check("stall transfer in_ready", bus_if.in_ready, 1);
        check("stall transfer out_valid", bus_if.out_valid, 0);

        // Reset during round 5 discards the block.
        bus_if.in_valid = 1'b1;
        bus_if.in       = vecs[0].pt;
        bus_if.key      = vecs[0].key;
        tick();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre-reset idx", rnd_idx, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset in_ready", bus_if.in_ready, 1);
        check("mid reset out_valid", bus_if.out_valid, 0);
        check("mid reset rnd_idx", rnd_idx, 0);
        check("mid reset cipher", bus_if.cipher, 0);
        wait_out_valid(15, edges);
        check("mid reset no result", bus_if.out_valid, 0);
        run_vec(vecs[1]);

        // Reset wins over a same-edge request.
        bus_if.in_valid = 1'b1;
        bus_if.in       = vecs[0].pt;
        bus_if.key      = vecs[0].key;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        check("rst vs request idx", rnd_idx, 0);
        check("rst vs request in_ready", bus_if.in_ready, 1);

`ifdef AES_128_SCHED_ABORT_EN
        run_vec(vecs[0]);
        bus_if.in_valid = 1'b1;
        bus_if.in       = vecs[1].pt;
        bus_if.key      = vecs[1].key;
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        tick();
        check("abort pre idx", rnd_idx, 3);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check("abort in_ready", bus_if.in_ready, 1);
        check("abort rnd_idx", rnd_idx, 0);
        check("abort cipher kept", bus_if.cipher, vecs[0].ct);
        wait_out_valid(15, edges);
        check("abort no result", bus_if.out_valid, 0);

        // Abort in IDLE is ignored; the request is still taken.
        bus_if.abort    = 1'b1;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.abort    = 1'b0;
        bus_if.in_valid = 1'b0;
        check("idle abort ignored", rnd_idx, 1);
        bus_if.out_ready = 1'b0;
        wait_out_valid(20, edges);
        check("abort-done cipher", bus_if.cipher, vecs[1].ct);
        bus_if.abort     = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check("abort+transfer in_ready", bus_if.in_ready, 1);
        check("abort+transfer cipher", bus_if.cipher, vecs[1].ct);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/aes_128_round_sched.md
AES_128_ROUND_SCHED -- requirements
Module: aes_128_round_sched

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  plaintext/key request valid.
REQ-004 in_ready  output  1  block can accept a request.
REQ-005 in  input  128  plaintext block (bit 127 = first byte MSB, FIPS-197 order).
REQ-006 key  input  128  cipher key, same byte order.
REQ-007 out_valid  output  1  cipher result valid.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 cipher  output  128  registered ciphertext.
REQ-010 rnd_state  output  128  current state to external round unit.
REQ-011 rnd_key  output  128  previous round key k(i-1) to external key-expansion unit.
REQ-012 rnd_idx  output  4  round number i (1..10); 0 when not in ROUND.
REQ-013 rnd_last  output  1  high when i = 10 (round unit omits MixColumns).
REQ-014 rnd_key_in  input  128  k(i) = expand(rnd_key, rcon(rnd_idx)), combinational return.
REQ-015 rnd_state_in  input  128  Round(rnd_state, rnd_key_in, rnd_last), combinational return.

Function
REQ-016 FSM states IDLE, ROUND, DONE; encoding free.
REQ-017 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 IDLE & in_valid: at that edge, state_reg <= in XOR key, key_reg <= key, idx <= 1, go ROUND; in/key ignored at all other times.
REQ-019 ROUND, each edge: state_reg <= rnd_state_in, key_reg <= rnd_key_in, idx <= idx+1.
REQ-020 ROUND with idx = 10: cipher <= rnd_state_in, idx <= 0, go DONE.
REQ-021 rnd_state = state_reg, rnd_key = key_reg, rnd_idx = idx (registers, no combinational path from inputs).
REQ-022 rnd_last = (FSM in ROUND) & (idx = 10).
REQ-023 Latency: out_valid high exactly 11 cycles after the cycle in which the request handshake occurred (1 accept + 10 rounds).
REQ-024 DONE holds out_valid and cipher stable until out_ready = 1; transfer edge returns to IDLE.
REQ-025 Minimum request period 12 cycles (out_ready held high); no accept in the same cycle as result transfer.
REQ-026 cipher retains last result after transfer until next round-10 capture.
REQ-027 in_valid in ROUND/DONE has no effect; requester must hold it until in_ready.

Reset
REQ-028 rst = 1 at an edge: FSM <= IDLE, state_reg, key_reg, cipher <= 0, idx <= 0; out_valid = 0, in_ready = 1 from the next cycle.
REQ-029 Reset in ROUND or DONE discards the block; no out_valid follows.
REQ-030 rst dominates every other input, including a same-edge request.

Configuration
REQ-031 Macro AES_128_SCHED_ABORT_EN: when defined, add input abort (1 bit, after out_ready).
REQ-032 With macro: abort = 1 in ROUND or DONE returns FSM to IDLE at that edge, idx <= 0, cipher unchanged, no out_valid for the discarded block.
REQ-033 With macro: abort in IDLE ignored; in DONE with out_ready = 1 on the same edge, the transfer completes normally (abort has no additional effect).
REQ-034 Without macro: no abort port; behaviour exactly REQ-016..REQ-030.

Verification (bench wires the team's combinational round and key-expansion logic to rnd_*)
REQ-035 in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid 11 cycles after accept, cipher=3925841d02dc09fbdc118597196a0b32.
REQ-036 in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> cipher=69c4e0d86a7b0430d8cdb78070b4c55a; rnd_idx steps 1..10, rnd_last only at 10.
REQ-037 Both vectors back-to-back, in_valid held high, out_ready=1 -> accepts 12 cycles apart, both results correct, in order.
REQ-038 out_ready low 5 cycles in DONE -> out_valid and cipher stable all 5 cycles; new in_valid/in changes ignored; in_ready 0.
REQ-039 rst asserted at round 5 -> next cycle in_ready=1, out_valid=0, rnd_idx=0; following request yields correct cipher.
REQ-040 AES_128_SCHED_ABORT_EN defined, abort at round 3 -> IDLE next cycle, no out_valid, cipher keeps prior value; abort with out_ready in DONE -> normal transfer.
